// File: rtl/blinky_pkg.sv
// Shared definitions for the LED pattern player: FSM states, PROM word field
// positions and the hold-time helper.
package blinky_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SHOW  = 3'd3,
    NEXT  = 3'd4
  } state_t;

  // PROM word layout: [31] end marker, [15:8] hold in ticks, [LED_W-1:0] pattern.
  localparam int PAT_LSB  = 0;
  localparam int HOLD_LSB = 8;
  localparam int HOLD_W   = 8;
  localparam int END_BIT  = 31;

  // A hold of zero would never expire cleanly, so it is promoted to one tick.
  function automatic logic [HOLD_W-1:0] hold_eff(input logic [HOLD_W-1:0] h);
    return (h == '0) ? HOLD_W'(1) : h;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running tick generator: while run is high, pulses tick once every
// PRESCALE cycles. clear restarts the count at zero and wins over run.
module tick_prescaler #(
  parameter int PRESCALE = 1200000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick on the last count of each period, only while running.
  assign tick = run && (cnt_q == CNT_W'(PRESCALE - 1));

  // Next-count logic: clear, wrap on tick, increment while running, else hold.
  always_comb begin
    // NOTE: assign a default first so every path writes cnt_d; otherwise a latch is inferred.
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pattern_player.sv
// Walks a registered-output pattern PROM, shows each word's LED pattern for
// its hold time in prescaled ticks, and wraps to address 0 on an end marker
// or past LAST_ADDR. All outputs come straight from flops.
module led_pattern_player #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32,
  parameter int LED_W     = 8,
  parameter int LAST_ADDR = 63,
  parameter int PRESCALE  = 1200000,
  parameter int READ_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              restart,
  output logic [ADDR_W-1:0] prom_addr,
  input  logic [DATA_W-1:0] prom_dout,
  output logic [LED_W-1:0]  leds,
  output logic              frame_strobe,
  output logic              busy
);

  import blinky_pkg::*;

  localparam int LAT_W = $clog2(READ_LAT + 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LED_W-1:0]    leds_q, leds_d;
  logic                strobe_q, strobe_d;
  logic                busy_q, busy_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  // Captured PROM word, kept as the three fields that matter.
  logic [LED_W-1:0]    wpat_q, wpat_d;
  logic [HOLD_W-1:0]   whold_q, whold_d;
  logic                wend_q, wend_d;

  logic                tick;
  logic                presc_clear;
  logic                presc_run;

  // Only pattern, hold and end-marker bits are decoded; the rest is ignored.
  logic                unused_dout;
  assign unused_dout = ^prom_dout;

  // The prescaler restarts for every new frame and on restart, and only
  // advances while a pattern is on display with play still requested.
  assign presc_clear = restart || (state_q == LOAD);
  assign presc_run   = enable && !restart && (state_q == SHOW);

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (presc_clear),
    .run   (presc_run),
    .tick  (tick)
  );

  // Next-state and datapath: restart first, then pause, then normal play.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    leds_d   = leds_q;
    strobe_d = 1'b0;
    lat_d    = lat_q;
    hold_d   = hold_q;
    wpat_d   = wpat_q;
    whold_d  = whold_q;
    wend_d   = wend_q;

    if (restart) begin
      addr_d  = '0;
      lat_d   = '0;
      hold_d  = '0;
      state_d = enable ? FETCH : IDLE;
    end else if (!enable) begin
      // Pause: leds and address are left alone so play resumes on the same word.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          lat_d   = '0;
          state_d = FETCH;
        end
        FETCH: begin
          if (lat_q == LAT_W'(READ_LAT)) begin
            wpat_d  = prom_dout[PAT_LSB +: LED_W];
            whold_d = prom_dout[HOLD_LSB +: HOLD_W];
            wend_d  = prom_dout[END_BIT];
            state_d = LOAD;
          end else begin
            lat_d = lat_q + 1'b1;
          end
        end
        LOAD: begin
          leds_d   = wpat_q;
          strobe_d = 1'b1;
          hold_d   = hold_eff(whold_q);
          state_d  = SHOW;
        end
        SHOW: begin
          if (tick) begin
            hold_d = hold_q - 1'b1;
            if (hold_q == HOLD_W'(1)) state_d = NEXT;
          end
        end
        NEXT: begin
          if (wend_q || (addr_q == ADDR_W'(LAST_ADDR))) addr_d = '0;
          else                                          addr_d = addr_q + 1'b1;
          lat_d   = '0;
          state_d = FETCH;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State, output and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      leds_q   <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      lat_q    <= '0;
      hold_q   <= '0;
      wpat_q   <= '0;
      whold_q  <= '0;
      wend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      leds_q   <= leds_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      lat_q    <= lat_d;
      hold_q   <= hold_d;
      wpat_q   <= wpat_d;
      whold_q  <= whold_d;
      wend_q   <= wend_d;
    end
  end

  assign prom_addr    = addr_q;
  assign leds         = leds_q;
  assign frame_strobe = strobe_q;
  assign busy         = busy_q;

endmodule
